// File: rtl/row_config_loader_if.sv
// Config-memory read port and row init bus between the row loader and its fabric.
// The loader drives the read request, the config word and the init strobes; the memory returns read data.
`ifndef PE_inst
`define PE_inst [31:0]
`endif

interface row_config_loader_if #(
  parameter int CFG_AW = 8
);
  logic              cfg_rd_en;
  logic [CFG_AW-1:0] cfg_rd_addr;
  logic `PE_inst     cfg_rd_data;
  logic `PE_inst     PE_config;
  logic              init_en;
  logic [4:0]        init_sel;

  modport master (
    output cfg_rd_en, cfg_rd_addr, PE_config, init_en, init_sel,
    input  cfg_rd_data
  );

  modport slave (
    input  cfg_rd_en, cfg_rd_addr, PE_config, init_en, init_sel,
    output cfg_rd_data
  );
endinterface

// File: rtl/row_config_loader.sv
// Row configuration loader: fetches one config word per target (LSU, PE_0..PE_3),
// broadcasts each with a one-hot init strobe, then enables the row for a bounded or open-ended run.
`ifndef PE_inst
`define PE_inst [31:0]
`endif

module row_config_loader #(
  parameter int CFG_AW  = 8,
  parameter int NUM_TGT = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [CFG_AW-1:0]      base_addr,
  input  logic [15:0]            run_len,
  row_config_loader_if.master    cfg,
  output logic                   run,
  output logic                   busy,
  output logic                   done,
  output logic                   abort
);

  typedef enum logic [2:0] {IDLE, FETCH, CAPT, LOAD, RUN, DONE} state_t;

  localparam logic [2:0] K_LAST = 3'(NUM_TGT - 1);

  state_t            state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [CFG_AW-1:0] base_q, base_d;
  logic [CFG_AW-1:0] addr_q, addr_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       rem_q, rem_d;
  logic `PE_inst     pe_q, pe_d;
  logic              rd_en_q, rd_en_d;
  logic              init_en_q, init_en_d;
  logic [4:0]        init_sel_q, init_sel_d;
  logic              run_q, run_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    base_d  = base_q;
    len_d   = len_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    pe_d    = pe_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          base_d  = base_addr;
          len_d   = run_len;
          k_d     = '0;
        end
      end
      FETCH: state_d = stop ? IDLE : CAPT;
      CAPT: begin
        pe_d    = cfg.cfg_rd_data;
        state_d = stop ? IDLE : LOAD;
      end
      LOAD: begin
        if (stop) begin
          state_d = IDLE;
        end else if (k_q == K_LAST) begin
          state_d = RUN;
          rem_d   = len_q;
        end else begin
          state_d = FETCH;
          k_d     = k_q + 3'd1;
        end
      end
      RUN: begin
        // A stop landing on the final counted cycle still yields a single DONE.
        if (stop || (len_q != '0 && rem_q == 16'd1)) begin
          state_d = DONE;
        end else if (len_q != '0) begin
          rem_d = rem_q - 16'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered: derive them from the state being entered.
    if (state_d == FETCH) begin
      addr_d = base_d + CFG_AW'(k_d);
    end
    rd_en_d    = (state_d == FETCH);
    init_en_d  = (state_d == LOAD);
    init_sel_d = (state_d == LOAD) ? (5'b10000 >> k_d) : '0;
    run_d      = (state_d == RUN);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    abort_d    = stop && (state_q == FETCH || state_q == CAPT || state_q == LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      pe_q       <= '0;
      rd_en_q    <= 1'b0;
      init_en_q  <= 1'b0;
      init_sel_q <= '0;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      pe_q       <= pe_d;
      rd_en_q    <= rd_en_d;
      init_en_q  <= init_en_d;
      init_sel_q <= init_sel_d;
      run_q      <= run_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  assign cfg.cfg_rd_en   = rd_en_q;
  assign cfg.cfg_rd_addr = addr_q;
  assign cfg.PE_config   = pe_q;
  assign cfg.init_en     = init_en_q;
  assign cfg.init_sel    = init_sel_q;
  assign run             = run_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign abort           = abort_q;

endmodule
